// File: rtl/cmp_window_max.sv
// rtl/cmp_window_max.sv - windowed running maximum and gt/eq/lt tally driven by an external 4-bit comparator
module cmp_window_max #(
    parameter int WIDTH = 4,
    parameter int WIN   = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic [WIDTH-1:0] cur_max,
    input  logic             cmp_gt,
    input  logic             cmp_eq,
    input  logic             cmp_lt,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] gt_cnt,
    output logic [CNT_W-1:0] eq_cnt,
    output logic [CNT_W-1:0] lt_cnt,
    output logic             flag_err
);

    // Sample counter must reach WIN itself, not just WIN-1.
    localparam int SC_W = $clog2(WIN + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FIRST = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [SC_W-1:0]  sample_cnt;
    logic [SC_W-1:0]  sample_cnt_nx;
    logic [WIDTH-1:0] max_nx;
    logic [CNT_W-1:0] gt_nx;
    logic [CNT_W-1:0] eq_nx;
    logic [CNT_W-1:0] lt_nx;
    logic             err_nx;
    logic [2:0]       flags;
    logic             flags_onehot;
    logic             last_sample;

    assign flags        = {cmp_gt, cmp_eq, cmp_lt};
    assign flags_onehot = (flags == 3'b100) || (flags == 3'b010) || (flags == 3'b001);
    // The sample being accepted now is the WIN-th one.
    assign last_sample  = (sample_cnt == SC_W'(WIN - 1));

    // Next-state and next-value logic; every register holds unless a rule below fires.
    always_comb begin
        state_nx      = state;
        sample_cnt_nx = sample_cnt;
        max_nx        = cur_max;
        gt_nx         = gt_cnt;
        eq_nx         = eq_cnt;
        lt_nx         = lt_cnt;
        err_nx        = flag_err;
        case (state)
            IDLE: begin
                // Results of the previous window stay visible until the next start;
                // cur_max is kept so the comparator still sees the old peak.
                if (start) begin
                    state_nx      = FIRST;
                    sample_cnt_nx = '0;
                    gt_nx         = '0;
                    eq_nx         = '0;
                    lt_nx         = '0;
                    err_nx        = 1'b0;
                end
            end
            FIRST: begin
                // First sample seeds the maximum; flags compare against a stale value so they are ignored.
                if (in_valid) begin
                    max_nx        = in_data;
                    sample_cnt_nx = SC_W'(1);
                    state_nx      = RUN;
                end
            end
            RUN: begin
                if (in_valid) begin
                    sample_cnt_nx = sample_cnt + SC_W'(1);
                    if (flags_onehot) begin
                        if (cmp_gt) begin
                            max_nx = in_data;
                            gt_nx  = gt_cnt + CNT_W'(1);
                        end else if (cmp_eq) begin
                            eq_nx = eq_cnt + CNT_W'(1);
                        end else begin
                            lt_nx = lt_cnt + CNT_W'(1);
                        end
                    end else begin
                        err_nx = 1'b1;
                    end
                    if (last_sample) begin
                        state_nx = DONE;
                    end
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // State and result registers; busy/done are registered from the next state so they align with it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            sample_cnt <= '0;
            cur_max    <= '0;
            gt_cnt     <= '0;
            eq_cnt     <= '0;
            lt_cnt     <= '0;
            flag_err   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_nx;
            sample_cnt <= sample_cnt_nx;
            cur_max    <= max_nx;
            gt_cnt     <= gt_nx;
            eq_cnt     <= eq_nx;
            lt_cnt     <= lt_nx;
            flag_err   <= err_nx;
            busy       <= (state_nx == FIRST) || (state_nx == RUN);
            done       <= (state_nx == DONE);
        end
    end

endmodule

// File: tb/tb_cmp_window_max.sv
// tb/tb_cmp_window_max.sv - self-checking bench for cmp_window_max
module tb_cmp_window_max;
    localparam int WIDTH = 4;
    localparam int WIN   = 8;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             in_valid = 1'b0;
    logic [WIDTH-1:0] in_data = '0;
    logic             corrupt = 1'b0;
    logic [2:0]       bad_pat = 3'b101;
    logic [WIDTH-1:0] cur_max;
    logic             cmp_gt, cmp_eq, cmp_lt;
    logic             busy, done, flag_err;
    logic [CNT_W-1:0] gt_cnt, eq_cnt, lt_cnt;

    int n_chk = 0;
    int n_fail = 0;
    bit chk_on = 1'b0;

    cmp_window_max #(.WIDTH(WIDTH), .WIN(WIN), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
        .cur_max(cur_max), .cmp_gt(cmp_gt), .cmp_eq(cmp_eq), .cmp_lt(cmp_lt),
        .busy(busy), .done(done), .gt_cnt(gt_cnt), .eq_cnt(eq_cnt), .lt_cnt(lt_cnt),
        .flag_err(flag_err)
    );

    always #5 clk = ~clk;

    // External comparator, with optional flag corruption.
    always_comb begin
        if (corrupt) begin
            {cmp_gt, cmp_eq, cmp_lt} = bad_pat;
        end else begin
            cmp_gt = (in_data > cur_max);
            cmp_eq = (in_data == cur_max);
            cmp_lt = (in_data < cur_max);
        end
    end

    // Reference model: phase plus the list of samples accepted in the current window.
    int m_state = 0;
    int m_base = 0;
    int q[$];
    bit qc[$];
    int e_g, e_e, e_l;
    bit e_er;

    function automatic int e_max();
        int m;
        if (q.size() == 0) return m_base;
        m = q[0];
        for (int i = 1; i < q.size(); i++)
            if (!qc[i] && q[i] > m) m = q[i];
        return m;
    endfunction

    function automatic void e_counts(output int g, output int e, output int l, output bit er);
        int r;
        g = 0; e = 0; l = 0; er = 1'b0;
        if (q.size() == 0) return;
        r = q[0];
        for (int i = 1; i < q.size(); i++) begin
            if (qc[i]) er = 1'b1;
            else if (q[i] > r) begin g++; r = q[i]; end
            else if (q[i] == r) e++;
            else l++;
        end
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            m_state = 0; m_base = 0; q.delete(); qc.delete();
        end else begin
            case (m_state)
                0: if (start) begin m_base = e_max(); q.delete(); qc.delete(); m_state = 1; end
                1: if (in_valid) begin q.push_back(int'(in_data)); qc.push_back(1'b0); m_state = 2; end
                2: if (in_valid) begin
                    q.push_back(int'(in_data)); qc.push_back(corrupt);
                    if (q.size() == WIN) m_state = 3;
                end
                default: m_state = 0;
            endcase
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_chk++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, want, $time);
        end
    endtask

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        if (chk_on) begin
            e_counts(e_g, e_e, e_l, e_er);
            check("cur_max", cur_max, e_max());
            check("gt_cnt", gt_cnt, e_g);
            check("eq_cnt", eq_cnt, e_e);
            check("lt_cnt", lt_cnt, e_l);
            check("flag_err", flag_err, e_er);
            check("busy", busy, (m_state == 1 || m_state == 2));
            check("done", done, (m_state == 3));
        end
    end

    int win_s[8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        start = 1'b0; in_valid = 1'b0; corrupt = 1'b0;
        repeat (n) tick();
    endtask

    task automatic send(input int d, input bit c, input bit s);
        in_valid = 1'b1; in_data = d[WIDTH-1:0]; corrupt = c; start = s;
        tick();
        in_valid = 1'b0; corrupt = 1'b0; start = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic run_win(input int gap, input int bad, input int mid_start, input bit skip_start);
        if (!skip_start) do_start();
        for (int i = 0; i < 8; i++) begin
            send(win_s[i], (i == bad), (i == mid_start));
            if (i < 7) idle(gap);
        end
    endtask

    task automatic check_done_lit(input string tag, input int mx, input int g, input int e,
                                  input int l, input int er);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (done === 1'b1) begin ok = 1'b1; break; end
            tick();
        end
        check({tag, " done_seen"}, ok, 1);
        if (ok) begin
            check({tag, " cur_max"}, cur_max, mx);
            check({tag, " gt"}, gt_cnt, g);
            check({tag, " eq"}, eq_cnt, e);
            check({tag, " lt"}, lt_cnt, l);
            check({tag, " err"}, flag_err, er);
            check({tag, " busy"}, busy, 0);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        idle(2);
        chk_on = 1'b1;
        check("reset cur_max", cur_max, 0);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        rst_n = 1'b1;
        idle(1);

        win_s = '{3, 5, 5, 2, 9, 9, 1, 4};
        run_win(0, -1, -1, 1'b0);
        check_done_lit("basic", 9, 2, 2, 3, 0);
        idle(2);

        run_win(2, -1, -1, 1'b0);
        check_done_lit("gaps", 9, 2, 2, 3, 0);
        idle(2);

        bad_pat = 3'b101;
        run_win(0, 2, -1, 1'b0);
        check_done_lit("corrupt", 9, 2, 1, 3, 1);
        idle(1);

        do_start();
        check("restart err_clr", flag_err, 0);
        check("restart gt_clr", gt_cnt, 0);
        check("restart max_kept", cur_max, 9);
        run_win(0, -1, 3, 1'b1);
        check_done_lit("restart", 9, 2, 2, 3, 0);
        do_start();
        check("start_in_done busy", busy, 0);
        idle(2);

        win_s = '{0, 0, 0, 0, 0, 0, 0, 0};
        run_win(0, -1, -1, 1'b0);
        check_done_lit("zeros", 0, 0, 7, 0, 0);
        idle(1);

        win_s = '{7, 3, 11, 6, 0, 0, 0, 0};
        do_start();
        for (int i = 0; i < 4; i++) send(win_s[i], 1'b0, 1'b0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("midrst cur_max", cur_max, 0);
        check("midrst gt", gt_cnt, 0);
        check("midrst busy", busy, 0);
        for (int i = 0; i < 4; i++) send(12, 1'b0, 1'b0);
        check("nostart cur_max", cur_max, 0);
        check("nostart busy", busy, 0);

        win_s = '{15, 14, 13, 12, 11, 10, 9, 8};
        run_win(0, -1, -1, 1'b0);
        check_done_lit("desc", 15, 0, 0, 7, 0);
        idle(1);

        for (int c = 0; c < 3000; c++) begin
            logic [2:0] p;
            start    = ($urandom_range(0, 5) == 0);
            in_valid = ($urandom_range(0, 1) == 1);
            in_data  = WIDTH'($urandom_range(0, 15));
            corrupt  = ($urandom_range(0, 9) == 0);
            p = 3'($urandom_range(0, 7));
            while (p == 3'b100 || p == 3'b010 || p == 3'b001) p = 3'($urandom_range(0, 7));
            bad_pat = p;
            rst_n = ($urandom_range(0, 199) != 0);
            tick();
        end
        rst_n = 1'b1;
        idle(2);

        chk_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
